dct_transpose_buffer: RTL and testbench

Ping-pong 8x8 transpose buffer between the row pass and the column pass of the 2D DCT. It accepts one 8-sample row per handshake from the row `fastDCT8` instance and emits one 8-sample column per handshake to the column `fastDCT8` instance. Two banks allow one block to fill while the previous block drains, so sustained throughput is one row in and one column out per cycle.

---
 rtl/dct_pkg.sv | 10 +
 rtl/dct_tp_bank.sv | 28 ++
 rtl/dct_transpose_buffer.sv | 68 ++++++
 tb/tb_dct_transpose_buffer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared DCT constants and lane-slicing helper for the 8-point DCT data path.
package dct_pkg;
  localparam int DCT_N = 8;
  localparam int DCT_W = 9;

  // Lane k of a packed 8-lane vector.
  function automatic logic [DCT_W-1:0] lane(input logic [DCT_N*DCT_W-1:0] vec, input int k);
    return vec[DCT_W*k +: DCT_W];
  endfunction
endpackage

// File: rtl/dct_tp_bank.sv
// One 8x8 sample bank: whole-row write port, combinational whole-column read mux.
module dct_tp_bank
  import dct_pkg::*;
#(
  parameter int W = DCT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [2:0]         row,
  input  logic [DCT_N*W-1:0] data,
  input  logic [2:0]         col,
  output logic [DCT_N*W-1:0] col_data
);
  logic [DCT_N-1:0][DCT_N-1:0][W-1:0] mem;  // mem[row][col]

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      for (int c = 0; c < DCT_N; c++) mem[row][c] <= data[W*c +: W];
    end
  end

  for (genvar r = 0; r < DCT_N; r++) begin : g_rd
    assign col_data[W*r +: W] = mem[r][col];
  end
endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer: rows in from the row DCT, columns out to the column DCT.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int W = DCT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DCT_N*W-1:0] in_row,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DCT_N*W-1:0] out_col,
  output logic [2:0]         out_col_idx,
  output logic               out_last
);
  logic [1:0]                full;
  logic                      wr_bank, rd_bank;
  logic [2:0]                wr_row, rd_col;
  logic [1:0][DCT_N*W-1:0]   bank_col;
  logic                      wr_fire, rd_fire, wr_done, rd_done;

  // Handshake flags come only from registered state.
  assign in_ready    = !full[wr_bank];
  assign out_valid   = full[rd_bank];
  assign wr_fire     = in_valid && in_ready;
  assign rd_fire     = out_valid && out_ready;
  assign wr_done     = wr_fire && (wr_row == 3'd7);
  assign rd_done     = rd_fire && (rd_col == 3'd7);
  assign out_col     = bank_col[rd_bank];
  assign out_col_idx = rd_col;
  assign out_last    = out_valid && (rd_col == 3'd7);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dct_tp_bank #(.W(W)) u_bank (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (wr_fire && (wr_bank == 1'(b))),
      .row      (wr_row),
      .data     (in_row),
      .col      (rd_col),
      .col_data (bank_col[b])
    );
  end

  // Set and clear can never target the same bank: a write needs !full, a read needs full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
    end else begin
      if (wr_fire) wr_row <= wr_row + 3'd1;
      if (rd_fire) rd_col <= rd_col + 3'd1;
      if (wr_done) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (rd_done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end
endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Directed + random bench for dct_transpose_buffer against a queue-based transpose model.
module tb_dct_transpose_buffer;
  import dct_pkg::*;
  localparam int W  = DCT_W;
  localparam int VW = DCT_N * W;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic          in_ready, out_valid, out_last;
  logic [VW-1:0] in_row = '0, out_col;
  logic [2:0]    out_col_idx;

  typedef struct {
    logic [VW-1:0] col;
    logic [2:0]    idx;
  } col_t;

  logic [VW-1:0] src_q[$];    // rows waiting to be offered
  logic [VW-1:0] rows_acc[$]; // accepted rows of the block being filled
  col_t          exp_q[$];    // columns the DUT still owes, in order
  int  n_chk = 0, n_fail = 0;
  bit  want_v = 1'b1, rand_mode = 1'b0;

  dct_transpose_buffer #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_col_idx(out_col_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rnd_row();
    return VW'({$urandom, $urandom, $urandom});
  endfunction

  // One clock: drive, check at negedge, advance model on the posedge.
  task automatic step();
    bit exp_rdy, exp_vld, acc, take;
    int blocks;
    if (rand_mode) begin
      want_v    = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = want_v && (src_q.size() > 0);
    in_row   = in_valid ? src_q[0] : rnd_row();
    @(negedge clk);
    blocks  = (exp_q.size() + 7) / 8;
    exp_rdy = (blocks < 2);
    exp_vld = (exp_q.size() > 0);
    chk("in_ready", VW'(in_ready), VW'(exp_rdy));
    chk("out_valid", VW'(out_valid), VW'(exp_vld));
    if (exp_vld) begin
      chk("out_col", out_col, exp_q[0].col);
      chk("out_col_idx", VW'(out_col_idx), VW'(exp_q[0].idx));
      chk("out_last", VW'(out_last), VW'(exp_q[0].idx == 3'd7));
    end else begin
      chk("out_last_idle", VW'(out_last), '0);
    end
    acc  = in_valid && exp_rdy;
    take = out_ready && exp_vld;
    @(posedge clk);
    #1;
    if (take) void'(exp_q.pop_front());
    if (acc) begin
      rows_acc.push_back(src_q.pop_front());
      if (rows_acc.size() == DCT_N) begin
        for (int c = 0; c < DCT_N; c++) begin
          col_t e;
          e.col = '0;
          for (int r = 0; r < DCT_N; r++) e.col[W*r +: W] = lane(rows_acc[r], c);
          e.idx = 3'(c);
          exp_q.push_back(e);
        end
        rows_acc.delete();
      end
    end
  endtask

  task automatic run_drain(input int budget);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    chk("rst_out_valid", VW'(out_valid), '0);
    chk("rst_out_last", VW'(out_last), '0);
    chk("rst_out_col", out_col, '0);
    chk("rst_out_col_idx", VW'(out_col_idx), '0);
    src_q.delete();
    rows_acc.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [VW-1:0] row;
    do_reset();

    // Single block, element (r,c) = 8r+c
    for (int r = 0; r < DCT_N; r++) begin
      for (int c = 0; c < DCT_N; c++) row[W*c +: W] = W'(8 * r + c);
      src_q.push_back(row);
    end
    want_v = 1'b1; out_ready = 1'b1;
    run_drain(100);

    // Signed extremes: row 0 = -256, row 7 = 255
    for (int r = 0; r < DCT_N; r++) begin
      for (int c = 0; c < DCT_N; c++)
        row[W*c +: W] = (r == 0) ? 9'h100 : (r == 7) ? 9'h0FF : 9'h000;
      src_q.push_back(row);
    end
    run_drain(100);

    // Back-to-back: three blocks, in_ready must never drop
    for (int i = 0; i < 3 * DCT_N; i++) src_q.push_back(rnd_row());
    run_drain(200);

    // Back-pressure: 17 rows with out_ready low
    for (int i = 0; i < 17; i++) src_q.push_back(rnd_row());
    out_ready = 1'b0;
    repeat (20) step();
    chk("bp_in_ready_low", VW'(in_ready), '0);
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) src_q.push_back(rnd_row());
    run_drain(200);

    // Random stalls over 20 blocks
    for (int i = 0; i < 20 * DCT_N; i++) src_q.push_back(rnd_row());
    rand_mode = 1'b1;
    run_drain(5000);
    rand_mode = 1'b0;
    want_v = 1'b1; out_ready = 1'b1;

    // Reset after 5 rows
    for (int i = 0; i < DCT_N; i++) src_q.push_back(rnd_row());
    repeat (5) step();
    do_reset();
    for (int i = 0; i < DCT_N; i++) src_q.push_back(rnd_row());
    run_drain(100);

    // Reset after 3 columns read
    for (int i = 0; i < DCT_N; i++) src_q.push_back(rnd_row());
    repeat (DCT_N + 3) step();
    do_reset();
    for (int i = 0; i < DCT_N; i++) src_q.push_back(rnd_row());
    run_drain(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
